// File: rtl/set_bit_walker.sv
// rtl/set_bit_walker.sv - serialises a request word into per-bit index beats, LSB- or MSB-first
module set_bit_walker #(
  parameter int WIDTH = 12,
  parameter int IDXW  = $clog2(WIDTH),
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  input  logic             data_val_i,
  output logic             data_ready_o,
  output logic [IDXW-1:0]  idx_o,
  output logic             idx_val_o,
  output logic             idx_last_o,
  input  logic             idx_ready_i,
  output logic             done_o,
  output logic [CNTW-1:0]  bit_cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] rem_q;
  logic             dir_q;
  logic [CNTW-1:0]  cnt_q;
  logic             done_q;
  logic [CNTW-1:0]  done_cnt_q;

  logic [IDXW-1:0]  sel_idx;
  logic [WIDTH-1:0] sel_mask;
  logic             one_left;
  logic             accept;
  logic             beat;

  // Edge-bit selection: the last hit of the scan wins, so scan against the desired end.
  always_comb begin
    sel_idx = '0;
    if (!dir_q) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (rem_q[i]) sel_idx = IDXW'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (rem_q[i]) sel_idx = IDXW'(i);
      end
    end
  end

  assign sel_mask = WIDTH'(1) << sel_idx;
  assign one_left = (rem_q != '0) && ((rem_q & (rem_q - WIDTH'(1))) == '0);

  always_comb begin
    state_d      = state_q;
    data_ready_o = 1'b0;
    idx_val_o    = 1'b0;
    idx_last_o   = 1'b0;
    idx_o        = '0;
    case (state_q)
      IDLE: begin
        data_ready_o = ~srst_i;
        if (data_val_i && !srst_i && data_i != '0) state_d = SCAN;
      end
      SCAN: begin
        idx_val_o  = 1'b1;
        idx_last_o = one_left;
        idx_o      = sel_idx;
        if (idx_ready_i && one_left) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = data_val_i & data_ready_o;
  assign beat   = idx_val_o & idx_ready_i;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      dir_q      <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (accept) begin
        if (data_i != '0) begin
          rem_q <= data_i;
          dir_q <= dir_i;
          cnt_q <= '0;
        end else begin
          done_q     <= 1'b1;
          done_cnt_q <= '0;
        end
      end
      if (beat) begin
        rem_q <= rem_q & ~sel_mask;
        cnt_q <= cnt_q + CNTW'(1);
        if (one_left) begin
          done_q     <= 1'b1;
          done_cnt_q <= cnt_q + CNTW'(1);
        end
      end
    end
  end

  assign done_o    = done_q;
  assign bit_cnt_o = done_cnt_q;

endmodule

// File: doc/set_bit_walker.md
# set_bit_walker

Downstream consumer of the edge-bit isolation stage. Accepts a WIDTH-bit request word, then walks its set bits one per handshake and emits each bit's index, LSB-first or MSB-first. Each step selects the next bit with the same lowest-set/highest-set isolation the upstream stage performs, then clears it from a working copy. Signals completion with the total bit count, so a multi-bit word can be serialised into per-bit service requests.

## Interface
- WIDTH, 12, request word width (≥2)
- IDXW, $clog2(WIDTH), index width
- CNTW, $clog2(WIDTH+1), bit-count width
- clk_i  in  1  clock; all state updates on rising edge
- srst_i  in  1  reset, asynchronous, active-high
- data_i  in  WIDTH  request word
- dir_i  in  1  0 = LSB-first, 1 = MSB-first; sampled with data_i
- data_val_i  in  1  data_i/dir_i valid
- data_ready_o  out  1  block can accept a word
- idx_o  out  IDXW  index of current set bit
- idx_val_o  out  1  idx_o valid
- idx_last_o  out  1  current index is the final bit of the word
- idx_ready_i  in  1  consumer accepts idx_o
- done_o  out  1  one-cycle pulse: word fully processed
- bit_cnt_o  out  CNTW  number of set bits in the finished word; valid with done_o

## Operation
- Registers: state {IDLE, SCAN}, rem_q[WIDTH], dir_q, cnt_q[CNTW], done_q, done_cnt_q.
- IDLE:
  - data_ready_o = 1 (forced 0 while srst_i is high).
  - On accept (data_val_i & data_ready_o) with data_i ≠ 0: rem_q <= data_i, dir_q <= dir_i, cnt_q <= 0, go to SCAN.
  - On accept with data_i == 0: stay in IDLE; done pulse next cycle with bit_cnt_o = 0. No index beats.
- SCAN:
  - data_ready_o = 0; idx_val_o = 1.
  - idx_o = position of the lowest set bit of rem_q (dir_q = 0) or the highest set bit (dir_q = 1). It is combinational from registers.
  - idx_last_o = 1 iff rem_q has exactly one bit set.
  - On beat (idx_val_o & idx_ready_i): clear the selected bit in rem_q and increment cnt_q.
  - If the beat is the last beat: go to IDLE, register done pulse with done_cnt_q = cnt_q + 1.
- While idx_ready_i = 0: idx_o, idx_last_o and rem_q hold stable; idx_val_o is never withdrawn.
- done_o = done_q; bit_cnt_o = done_cnt_q. bit_cnt_o holds its last value between pulses.
- Outputs in IDLE: idx_val_o = 0, idx_last_o = 0, idx_o = 0.
- Arithmetic: cnt_q never exceeds WIDTH. CNTW is sized so that WIDTH fits (WIDTH = 12 gives 4 bits).

## Timing
- Reset values: state = IDLE, rem_q = 0, cnt_q = 0, dir_q = 0, done_o = 0, bit_cnt_o = 0, idx_val_o = 0, idx_o = 0, idx_last_o = 0.
- data_ready_o = 0 during reset and 1 from the first cycle after deassertion.
- Latency: first index beat is valid in the cycle after accept.
- With idx_ready_i held high, a word with N set bits produces N beats on N consecutive cycles.
- done_o pulses in the cycle after the last beat. data_ready_o returns to 1 in that same cycle, so back-to-back words are possible: accept cycle → N beats → next accept.
- Zero word: done_o pulses in the cycle after accept; data_ready_o stays 1, so zero words can be accepted every cycle.
- Single-bit word: one beat with idx_last_o = 1.
- All-ones word: WIDTH beats, bit_cnt_o = WIDTH.
- Reset mid-SCAN: asynchronous abort. idx_val_o drops immediately, no done pulse, rem_q is cleared, and the partial word is lost.
- Reset in the cycle a done pulse is pending: the pulse is suppressed.
- data_val_i in SCAN is ignored (not accepted); the upstream stage must hold its word.

## Test plan
- WIDTH = 12, data_i = 12'h025, dir_i = 0, idx_ready_i = 1 → idx_o = 0, 2, 5 on three consecutive cycles; idx_last_o only with 5; next cycle done_o = 1, bit_cnt_o = 3, data_ready_o = 1.
- data_i = 12'h025, dir_i = 1 → idx_o = 5, 2, 0; idx_last_o with 0; bit_cnt_o = 3.
- data_i = 12'h000 → idx_val_o stays 0; done_o = 1 next cycle with bit_cnt_o = 0. A second zero word in the following cycle is also accepted.
- data_i = 12'hFFF, dir_i = 0, idx_ready_i toggling 1/0 → idx_o = 0..11, each held stable during stalls; idx_last_o with 11; bit_cnt_o = 12 (4'hC).
- data_i = 12'h800, dir_i = 0 → single beat idx_o = 11 with idx_last_o = 1; done with bit_cnt_o = 1.
- data_i = 12'h0F0, assert srst_i after the first beat (idx_o = 4) → idx_val_o = 0 immediately, no done_o. After release: data_ready_o = 1, and a new word 12'h002 yields idx_o = 1.
